// File: rtl/mvm_feeder.sv
// Front-end sequencer for the 8x8 matrix-vector multiply unit: streams bytes into the
// A row FIFOs and the B FIFO, captures the eight results on done, returns them, then clears.
module mvm_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 8,
  parameter int COLS       = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        abort,
  output logic [ROWS-1:0]             a_wren,
  output logic [DATA_WIDTH-1:0]       a_fifo_in,
  output logic                        b_wren,
  output logic [DATA_WIDTH-1:0]       b_fifo_in,
  input  logic                        mac_done,
  input  logic [3*DATA_WIDTH-1:0]     mac_out [ROWS],
  output logic                        mac_clr,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [3*DATA_WIDTH-1:0]     res_data,
  output logic [$clog2(ROWS)-1:0]     res_idx,
  output logic                        res_last,
  output logic                        busy
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int OW = 3 * DATA_WIDTH;
  localparam logic [RW-1:0]   ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0]   COL_LAST = CW'(COLS - 1);
  localparam logic [ROWS-1:0] ROW0_HOT = ROWS'(1);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, WAIT_DONE, SEND, CLEAR} state_t;

  state_t         state;
  logic [RW-1:0]  row;
  logic [CW-1:0]  col;
  logic [RW-1:0]  idx;
  logic [OW-1:0]  cap [ROWS];

  assign in_ready  = (state == IDLE) || (state == LOAD_A) || (state == LOAD_B);
  assign busy      = (state != IDLE);
  assign res_valid = (state == SEND);
  assign res_data  = cap[idx];
  assign res_idx   = idx;
  assign res_last  = res_valid && (idx == ROW_LAST);
  assign mac_clr   = (state == CLEAR);

  // NOTE: all state, including the capture buffer, uses non-blocking assignments so every
  // register samples pre-edge values; the buffer is reset because it is observable on res_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      idx       <= '0;
      a_wren    <= '0;
      a_fifo_in <= '0;
      b_wren    <= 1'b0;
      b_fifo_in <= '0;
      for (int i = 0; i < ROWS; i++) cap[i] <= '0;
    end else begin
      a_wren <= '0;
      b_wren <= 1'b0;
      if (abort && state != IDLE && state != CLEAR) begin
        state <= CLEAR;
        row   <= '0;
        col   <= '0;
        idx   <= '0;
      end else begin
        case (state)
          IDLE: if (in_valid) begin
            a_wren    <= ROW0_HOT << row;
            a_fifo_in <= in_data;
            col       <= CW'(1);
            state     <= LOAD_A;
          end
          LOAD_A: if (in_valid) begin
            a_wren    <= ROW0_HOT << row;
            a_fifo_in <= in_data;
            if (col == COL_LAST) begin
              col   <= '0;
              state <= LOAD_B;
            end else begin
              col <= col + CW'(1);
            end
          end
          LOAD_B: if (in_valid) begin
            b_wren    <= 1'b1;
            b_fifo_in <= in_data;
            col       <= '0;
            if (row == ROW_LAST) begin
              row   <= '0;
              state <= WAIT_DONE;
            end else begin
              row   <= row + RW'(1);
              state <= LOAD_A;
            end
          end
          // The last B write is still on the bus in the first WAIT_DONE cycle; skip it.
          WAIT_DONE: if (mac_done && !b_wren) begin
            cap   <= mac_out;
            idx   <= '0;
            state <= SEND;
          end
          SEND: if (res_ready) begin
            if (idx == ROW_LAST) begin
              idx   <= '0;
              state <= CLEAR;
            end else begin
              idx <= idx + RW'(1);
            end
          end
          CLEAR:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mvm_feeder.sv
// Scoreboard bench for mvm_feeder: directed jobs with a behavioural multiply unit,
// expected writes and results queued by the stimulus, checked by independent monitors.
module tb_mvm_feeder;

  typedef struct packed {
    logic       is_b;
    logic [2:0] row;
    logic [7:0] data;
  } wr_t;

  typedef struct packed {
    logic [2:0]  idx;
    logic [23:0] data;
    logic        last;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        abort;
  logic [7:0]  a_wren;
  logic [7:0]  a_fifo_in;
  logic        b_wren;
  logic [7:0]  b_fifo_in;
  logic        mac_done;
  logic [23:0] mac_out [8];
  logic        mac_clr;
  logic        res_valid;
  logic        res_ready;
  logic [23:0] res_data;
  logic [2:0]  res_idx;
  logic        res_last;
  logic        busy;

  mvm_feeder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .abort(abort),
    .a_wren(a_wren), .a_fifo_in(a_fifo_in), .b_wren(b_wren), .b_fifo_in(b_fifo_in),
    .mac_done(mac_done), .mac_out(mac_out), .mac_clr(mac_clr),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_idx(res_idx), .res_last(res_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  wr_t  exp_wr[$];
  res_t exp_res[$];
  int   cyc = 0;
  int   wr_cnt, first_wr, last_wr, clr_cnt = 0, clr_base;
  logic early = 1'b0;

  // NOTE: automatic so the concurrent monitors calling it do not share argument storage.
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural multiply unit: collects FIFO writes, raises done a few cycles after B is full.
  logic [7:0]  ma [8][8];
  logic [7:0]  mb [8];
  logic [23:0] model_out [8];
  logic        model_done;
  int          acol [8];
  int          bcnt, dly;

  function automatic logic [23:0] dot(int r);
    logic [23:0] s = '0;
    for (int c = 0; c < 8; c++) s += 24'(ma[r][c]) * 24'(mb[c]);
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst || mac_clr) begin
      model_done <= 1'b0;
      bcnt       <= 0;
      dly        <= 0;
      for (int i = 0; i < 8; i++) acol[i] <= 0;
    end else begin
      for (int r = 0; r < 8; r++)
        if (a_wren[r]) begin
          ma[r][acol[r] % 8] <= a_fifo_in;
          acol[r]            <= acol[r] + 1;
        end
      if (b_wren) begin
        mb[bcnt % 8] <= b_fifo_in;
        bcnt         <= bcnt + 1;
        if (bcnt == 7) dly <= 3;
      end else if (dly > 1) begin
        dly <= dly - 1;
      end else if (dly == 1) begin
        dly        <= 0;
        model_done <= 1'b1;
        for (int r = 0; r < 8; r++) model_out[r] <= dot(r);
      end
    end
  end

  always_comb begin
    mac_done = model_done | early;
    for (int i = 0; i < 8; i++) mac_out[i] = early ? 24'hABCDEF : model_out[i];
  end

  always @(posedge clk) cyc++;

  // Write monitor
  always @(negedge clk) begin
    if (a_wren != 8'h00 || b_wren) begin
      if (exp_wr.size() == 0) begin
        check("wr_unexpected", {23'd0, b_wren, a_wren}, 32'd0);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        check("a_wren", {24'd0, a_wren}, e.is_b ? 32'd0 : (32'd1 << e.row));
        check("b_wren", {31'd0, b_wren}, {31'd0, e.is_b});
        check("wr_data", {24'd0, e.is_b ? b_fifo_in : a_fifo_in}, {24'd0, e.data});
      end
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      wr_cnt++;
    end
  end

  // Result monitor: a result is consumed only on a handshake not overridden by abort
  always @(negedge clk) begin
    if (res_valid && res_ready && !abort) begin
      if (exp_res.size() == 0) begin
        check("res_unexpected", {8'd0, res_data}, 32'd0);
      end else begin
        res_t e;
        e = exp_res.pop_front();
        check("res_idx", {29'd0, res_idx}, {29'd0, e.idx});
        check("res_data", {8'd0, res_data}, {8'd0, e.data});
        check("res_last", {31'd0, res_last}, {31'd0, e.last});
      end
    end
    if (mac_clr) clr_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends bytes first..last of the 72-byte job: row r A[c]=c, then b[r]=r+1.
  task automatic send_range(int first, int last, bit gap);
    for (int k = first; k <= last; k++) begin
      int  r, p, n;
      wr_t e;
      r = k / 9;
      p = k % 9;
      e.is_b = (p == 8);
      e.row  = 3'(r);
      e.data = (p == 8) ? 8'(r + 1) : 8'(p);
      n = 0;
      while (!in_ready && n < 100) begin tick(); n++; end
      if (!in_ready) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = e.data;
      exp_wr.push_back(e);
      tick();
      if (gap) begin
        in_valid = 1'b0;
        tick();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic job_start();
    for (int i = 0; i < 8; i++) begin
      res_t e;
      e.idx  = 3'(i);
      e.data = 24'd168;
      e.last = (i == 7);
      exp_res.push_back(e);
    end
    wr_cnt   = 0;
    first_wr = -1;
    clr_base = clr_cnt;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin tick(); n++; end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_res_idx(int i);
    int n = 0;
    while (!(res_valid && res_idx == 3'(i)) && n < 2000) begin tick(); n++; end
    check("res_wait_valid", {31'd0, res_valid}, 32'd1);
    check("res_wait_idx", {29'd0, res_idx}, 32'(i));
  endtask

  task automatic job_end(int span);
    wait_idle();
    tick();
    check("wr_left", 32'(exp_wr.size()), 32'd0);
    check("res_left", 32'(exp_res.size()), 32'd0);
    check("wr_count", 32'(wr_cnt), 32'd72);
    check("clr_pulses", 32'(clr_cnt - clr_base), 32'd1);
    if (span > 0) check("wr_span", 32'(last_wr - first_wr + 1), 32'(span));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    abort     = 1'b0;
    res_ready = 1'b1;
    first_wr  = -1;
    wr_cnt    = 0;
    repeat (3) tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_outputs", {26'd0, |a_wren, b_wren, res_valid, mac_clr, res_last, |res_data}, 32'd0);
    rst = 1'b0;
    tick();

    // Streaming job: 72 back-to-back writes, results 168 each
    job_start();
    send_range(0, 71, 1'b0);
    job_end(72);

    // Same job with a one-cycle gap after every byte
    job_start();
    send_range(0, 71, 1'b1);
    job_end(143);

    // Result backpressure held at index 2
    job_start();
    send_range(0, 71, 1'b0);
    wait_res_idx(2);
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", {31'd0, res_valid}, 32'd1);
      check("bp_idx", {29'd0, res_idx}, 32'd2);
      check("bp_data", {8'd0, res_data}, 32'd168);
    end
    res_ready = 1'b1;
    job_end(-1);

    // Early done pulse during LOAD_A with garbage results on the bus
    job_start();
    send_range(0, 4, 1'b0);
    early = 1'b1;
    tick();
    early = 1'b0;
    check("early_busy", {31'd0, busy}, 32'd1);
    check("early_in_ready", {31'd0, in_ready}, 32'd1);
    check("early_res_valid", {31'd0, res_valid}, 32'd0);
    send_range(5, 71, 1'b0);
    job_end(-1);

    // Abort during SEND at index 4, then a fresh job
    job_start();
    send_range(0, 71, 1'b0);
    wait_res_idx(4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_res_valid", {31'd0, res_valid}, 32'd0);
    check("abort_mac_clr", {31'd0, mac_clr}, 32'd1);
    tick();
    check("abort_idle", {31'd0, busy}, 32'd0);
    check("abort_clr_done", {31'd0, mac_clr}, 32'd0);
    check("abort_res_left", 32'(exp_res.size()), 32'd4);
    check("abort_clr_pulses", 32'(clr_cnt - clr_base), 32'd1);
    exp_res.delete();
    job_start();
    send_range(0, 71, 1'b0);
    job_end(72);

    // Reset in LOAD_A at row 3, col 5
    wr_cnt = 0;
    send_range(0, 31, 1'b0);
    tick();
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_writes", {30'd0, |a_wren, b_wren}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("midrst_hold", {29'd0, |a_wren, b_wren, res_valid}, 32'd0);
    rst = 1'b0;
    tick();
    tick();
    check("midrst_wr_count", 32'(wr_cnt), 32'd32);
    check("midrst_wr_left", 32'(exp_wr.size()), 32'd0);
    check("midrst_in_ready2", {31'd0, in_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
